aes_inv_key_sched: RTL and testbench

- Inverse AES-128 key schedule engine for the decryption datapath.
- Loads the final round key (round 10) and walks the schedule backward, emitting round keys 10, 9, … 0 in decryption order over a valid/ready stream.
- Sits between the key register file and the inverse-cipher round unit; removes the need to store all 11 expanded keys.

---
 rtl/aes_inv_key_sched.sv | 197 +++++++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule: loads round key 10 and streams keys 10..0 over valid/ready.
// Define AES_INV_KSCHED_SHARED_SBOX_EN to share one S-box over four STEP cycles per key.
module aes_inv_key_sched #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [KW-1:0] last_key_i,
  output logic [KW-1:0] key_o,
  output logic [3:0]    round_o,
  output logic          key_valid_o,
  input  logic          key_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    state_o
);

  // Handshake: a key transfers on a rising edge where key_valid_o and key_ready_i
  // are both high; while key_valid_o is high without key_ready_i, key_o/round_o hold.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    STEP    = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Round constant used when stepping from round r back to r-1 (RCON[r-1]).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [3:0]    round_q, round_d;
  logic          done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1n, w2n, w3n;
  logic [31:0] rcon_word;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign w3n = w3 ^ w2;
  assign w2n = w2 ^ w1;
  assign w1n = w1 ^ w0;
  assign rcon_word = {rcon(round_q), 24'h0};

`ifdef AES_INV_KSCHED_SHARED_SBOX_EN
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] temp_q, temp_d;
  logic [7:0]  sel_byte;
  logic [7:0]  sub_byte;

  // Byte order realises RotWord: w3' bytes 2,1,0,3 feed result bytes 3,2,1,0.
  always_comb begin
    sel_byte = w3n[31:24];
    case (cnt_q)
      2'd0:    sel_byte = w3n[23:16];
      2'd1:    sel_byte = w3n[15:8];
      2'd2:    sel_byte = w3n[7:0];
      default: sel_byte = w3n[31:24];
    endcase
  end

  assign sub_byte = sbox(sel_byte);
`else
  logic [31:0] sub_word;

  assign sub_word = {sbox(w3n[23:16]), sbox(w3n[15:8]), sbox(w3n[7:0]), sbox(w3n[31:24])};
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
`ifdef AES_INV_KSCHED_SHARED_SBOX_EN
    cnt_d   = cnt_q;
    temp_d  = temp_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d   = last_key_i;
          round_d = LAST_ROUND;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (key_ready_i) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef AES_INV_KSCHED_SHARED_SBOX_EN
            state_d = STEP;
            cnt_d   = 2'd0;
`else
            key_d   = {w0 ^ sub_word ^ rcon_word, w1n, w2n, w3n};
            round_d = round_q - 4'd1;
`endif
          end
        end
      end
`ifdef AES_INV_KSCHED_SHARED_SBOX_EN
      STEP: begin
        case (cnt_q)
          2'd0: temp_d[23:16] = sub_byte;
          2'd1: temp_d[15:8]  = sub_byte;
          2'd2: temp_d[7:0]   = sub_byte;
          default: begin
            key_d   = {w0 ^ {temp_q, sub_byte} ^ rcon_word, w1n, w2n, w3n};
            round_d = round_q - 4'd1;
            state_d = PRESENT;
          end
        endcase
        cnt_d = cnt_q + 2'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q   <= '0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

`ifdef AES_INV_KSCHED_SHARED_SBOX_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      temp_q <= 24'h0;
    end else begin
      cnt_q  <= cnt_d;
      temp_q <= temp_d;
    end
  end
`endif

  assign key_o       = key_q;
  assign round_o     = round_q;
  assign key_valid_o = (state_q == PRESENT);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: directed FIPS-197 vectors, scoreboard queue plus monitor.
module tb_aes_inv_key_sched;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [127:0] last_key_i;
  logic [127:0] key_o;
  logic [3:0]   round_o;
  logic         key_valid_o;
  logic         key_ready_i;
  logic         busy_o;
  logic         done_o;
  logic [1:0]   state_o;

  aes_inv_key_sched dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .last_key_i  (last_key_i),
    .key_o       (key_o),
    .round_o     (round_o),
    .key_valid_o (key_valid_o),
    .key_ready_i (key_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .state_o     (state_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef AES_INV_KSCHED_SHARED_SBOX_EN
  localparam int GAP = 5;
`else
  localparam int GAP = 1;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic [131:0] exp_q[$];
  logic [127:0] fips_keys[11];
  logic [127:0] model_keys[11];

  logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: forward-schedule recurrence run backwards
  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_tbl[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rc(input int i);
    case (i)
      1: return 8'h01; 2: return 8'h02; 3: return 8'h04; 4: return 8'h08;
      5: return 8'h10; 6: return 8'h20; 7: return 8'h40; 8: return 8'h80;
      9: return 8'h1b; default: return 8'h36;
    endcase
  endfunction

  task automatic compute_model(input logic [127:0] last);
    logic [31:0] w[44];
    logic [31:0] t;
    w[40] = last[127:96]; w[41] = last[95:64]; w[42] = last[63:32]; w[43] = last[31:0];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc(i / 4), 24'h0};
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_keys(input bit use_model);
    for (int r = 10; r >= 0; r--)
      exp_q.push_back({4'(r), use_model ? model_keys[r] : fips_keys[r]});
  endtask

  // ---------------- monitor
  int cyc = 0, done_cnt = 0, valid_cnt = 0;
  int hs_cyc = 0, done_exp_cyc = -1;
  bit gap_pending = 0, hold_pending = 0;
  logic [131:0] held;
  logic [131:0] e;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      gap_pending  = 0;
      hold_pending = 0;
      done_exp_cyc = -1;
    end else begin
      cyc++;
      if (key_valid_o) valid_cnt++;
      if (done_o) begin
        done_cnt++;
        check("done_timing", 132'(cyc), 132'(done_exp_cyc));
        check("done_idle", {busy_o, key_valid_o}, 132'(0));
      end
      if (gap_pending && key_valid_o) begin
        check("step_latency", 132'(cyc - hs_cyc), 132'(GAP));
        gap_pending = 0;
      end
      if (hold_pending && key_valid_o) check("hold_stable", {round_o, key_o}, held);
      if (key_valid_o && key_ready_i) begin
        if (exp_q.size() == 0) check("sb_unexpected", {round_o, key_o}, 132'(0));
        else begin
          e = exp_q.pop_front();
          check("sb_key", {round_o, key_o}, e);
        end
        if (round_o != 4'd0) begin
          hs_cyc = cyc;
          gap_pending = 1;
        end else done_exp_cyc = cyc + 1;
      end
      hold_pending = key_valid_o && !key_ready_i;
      held = {round_o, key_o};
    end
  end

  // ---------------- driver tasks
  task automatic do_start(input logic [127:0] k);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    last_key_i = k;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk_i); #1;
      key_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    key_ready_i = 1'b1;
    check("done_once", 132'(done_cnt - d0), 132'(1));
    check("sb_drained", 132'(exp_q.size()), 132'(0));
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (n < 200) begin
      @(negedge clk_i);
      if (key_valid_o && round_o == r) break;
      n++;
    end
    check("wait_round_timeout", 132'(n < 200), 132'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_ni = 1'b0;
    start_i = 1'b0;
    last_key_i = '0;
    key_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_key", 132'(key_o), 132'(0));
    check("rst_round", 132'(round_o), 132'(0));
    check("rst_valid", 132'(key_valid_o), 132'(0));
    check("rst_busy", 132'(busy_o), 132'(0));
    check("rst_done", 132'(done_o), 132'(0));
    rst_ni = 1'b1;

    // FIPS-197 A.1 with a consumer that is always ready
    valid_cnt = 0;
    push_keys(0);
    do_start(fips_keys[10]);
    run_until_done(200, 0);
    check("valid_cycles", 132'(valid_cnt), 132'(11));

    // random backpressure
    push_keys(0);
    do_start(fips_keys[10]);
    run_until_done(1000, 1);

    // start while busy is ignored
    push_keys(0);
    do_start(fips_keys[10]);
    wait_round(4'd5);
    #2;
    start_i = 1'b1;
    last_key_i = 128'h00112233445566778899aabbccddeeff;
    repeat (3) @(posedge clk_i);
    #1;
    check("busy_mid_walk", 132'(busy_o), 132'(1));
    start_i = 1'b0;
    run_until_done(200, 0);

    // asynchronous reset at round 4, then a clean restart
    push_keys(0);
    do_start(fips_keys[10]);
    wait_round(4'd4);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 132'(key_valid_o), 132'(0));
    check("arst_busy", 132'(busy_o), 132'(0));
    check("arst_key", 132'(key_o), 132'(0));
    check("arst_round", 132'(round_o), 132'(0));
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    push_keys(0);
    do_start(fips_keys[10]);
    run_until_done(200, 0);

    // all-zero round-10 key, followed by a start in the done cycle
    compute_model(128'h0);
    check("model_r9", model_keys[9], 132'h55636363_00000000_00000000_00000000);
    check("model_r8", model_keys[8], 132'h2d000000_55636363_00000000_00000000);
    push_keys(1);
    do_start(128'h0);
    wait_round(4'd0);
    @(posedge clk_i); #1;
    check("done_cycle", {done_o, busy_o}, 132'b10);
    start_i = 1'b1;
    last_key_i = fips_keys[10];
    push_keys(0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("start_on_done_round", {key_valid_o, round_o}, {1'b1, 4'd10});
    run_until_done(200, 0);

    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
